// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg
//   Shared constants and helpers for the VRAM arbiter slice.
//   NUM_PORTS : host (port 0) plus three fetch clients (ports 1..3)
//   ADDR_W    : RAM word-address width
//   DATA_W    : RAM data width; BE_W byte enables per word
package vram_arbiter_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int BE_W      = DATA_W / 8;
    localparam int HOST_PORT = 0;

    // Round-robin pointer names a fetch port (1..3) directly.
    localparam logic [1:0] RR_PTR_RESET = 2'd1;

    // Pointer value after a fetch grant: the port just past the winner,
    // wrapping 3 -> 1. Input is the one-hot fetch grant (bit 0 = port 1).
    function automatic logic [1:0] next_rr_ptr(input logic [2:0] fetch_gnt);
        logic [1:0] ptr;
        ptr = RR_PTR_RESET;
        unique case (fetch_gnt)
            3'b001:  ptr = 2'd2;
            3'b010:  ptr = 2'd3;
            3'b100:  ptr = 2'd1;
            default: ptr = RR_PTR_RESET;
        endcase
        return ptr;
    endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick3.sv
// rr_pick3
//   Cyclic-priority picker for the three fetch ports.
//   i_req : request vector, bit 0 = port 1 ... bit 2 = port 3
//   i_ptr : highest-priority port this cycle (1..3)
//   o_gnt : one-hot grant, same bit mapping as i_req; zero when no request
module rr_pick3 (
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = 3'b000;
        case (i_ptr)
            2'd2: begin
                if      (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
            end
            2'd3: begin
                if      (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
            end
            // Pointer value 0 never occurs; treat it like 1.
            default: begin
                if      (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Single-ported VRAM arbiter: host (port 0) has priority but is limited
//   to HOST_MAX_STREAK consecutive grants while fetch clients wait; fetch
//   ports 1..3 share round-robin. One access per cycle, issued in the
//   grant cycle; read data returns one cycle later on the shared bus.
//   clk, rst            : clock, synchronous active-high reset
//   port_strobe/write   : per-port request and write flag
//   port_addr/wrdata/wrbytesel : packed per-port request fields
//   port_ack            : one-hot grant (combinational)
//   port_rdvalid        : one-hot read-data-valid, one cycle after a read grant
//   port_rddata         : shared read data (copy of bus_rddata)
//   bus_*               : RAM interface
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int HOST_MAX_STREAK = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          port_strobe,
    input  logic [NUM_PORTS-1:0]          port_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_wrdata,
    input  logic [NUM_PORTS*BE_W-1:0]     port_wrbytesel,
    output logic [NUM_PORTS-1:0]          port_ack,
    output logic [NUM_PORTS-1:0]          port_rdvalid,
    output logic [DATA_W-1:0]             port_rddata,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_wrdata,
    output logic [BE_W-1:0]               bus_wrbytesel,
    output logic                          bus_write,
    input  logic [DATA_W-1:0]             bus_rddata
);

    // Extra headroom keeps the counter at least one bit wide.
    localparam int STREAK_W = $clog2(HOST_MAX_STREAK + 2);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HOST_MAX_STREAK);

    logic [1:0]           r_rr_ptr;
    logic [STREAK_W-1:0]  r_host_streak;
    logic [NUM_PORTS-1:0] r_rdvalid;

    logic [2:0]           w_fetch_req;
    logic                 w_any_fetch;
    logic                 w_streak_full;
    logic [2:0]           w_fetch_pick;
    logic                 w_host_ack;
    logic [2:0]           w_fetch_ack;
    logic [NUM_PORTS-1:0] w_ack;

    assign w_fetch_req   = port_strobe[NUM_PORTS-1:1];
    assign w_any_fetch   = |w_fetch_req;
    assign w_streak_full = (r_host_streak == STREAK_MAX);

    rr_pick3 u_rr_pick3 (
        .i_req (w_fetch_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_fetch_pick)
    );

    // Host yields only when its streak is used up and a fetch port waits.
    assign w_host_ack  = !rst && port_strobe[HOST_PORT] && !(w_streak_full && w_any_fetch);
    assign w_fetch_ack = (rst || w_host_ack) ? 3'b000 : w_fetch_pick;
    assign w_ack       = {w_fetch_ack, w_host_ack};
    assign port_ack    = w_ack;

    always_comb begin
        bus_addr      = '0;
        bus_wrdata    = '0;
        bus_wrbytesel = '0;
        bus_write     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_ack[i]) begin
                bus_addr      = port_addr[i*ADDR_W +: ADDR_W];
                bus_wrdata    = port_wrdata[i*DATA_W +: DATA_W];
                bus_wrbytesel = port_wrbytesel[i*BE_W +: BE_W];
                bus_write     = port_write[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= RR_PTR_RESET;
            r_host_streak <= '0;
            r_rdvalid     <= '0;
        end else begin
            if (|w_fetch_ack) begin
                r_rr_ptr <= next_rr_ptr(w_fetch_ack);
            end
            // With a fetch strobe pending somebody is always granted, so the
            // fall-through covers both "fetch granted" and "no fetch waiting".
            if (w_host_ack && w_any_fetch) begin
                if (!w_streak_full) begin
                    r_host_streak <= r_host_streak + 1'b1;
                end
            end else begin
                r_host_streak <= '0;
            end
            r_rdvalid <= w_ack & ~port_write;
        end
    end

    // A read granted just before reset rises would otherwise report valid
    // data during the reset cycle; mask it.
    assign port_rdvalid = rst ? '0 : r_rdvalid;
    assign port_rddata  = bus_rddata;

endmodule
